// File: rtl/wb_result_buffer.sv
// wb_result_buffer
//
// In-order writeback collector for the scoreboard. Issue allocates a
// transaction ID at the tail; the four writeback ports (flu, load, store,
// fpu) park their result and exception in the entry for that ID in any
// order; commit sees entries strictly in allocation order from the head.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 drop every entry and rewind the pointers
//   alloc_valid_i           issue asks for an ID
//   alloc_ready_o           buffer not full
//   alloc_trans_id_o        ID granted this cycle (current tail)
//   wb_valid_i[p]           writeback strobe, p = 0 flu, 1 load, 2 store, 3 fpu
//   wb_trans_id_i[p]        target entry
//   wb_result_i[p]          result data
//   wb_exception_i[p]       exception (cause, tval, valid)
//   commit_valid_o          head entry is allocated and written back
//   commit_trans_id_o       head pointer
//   commit_result_o         head result
//   commit_exception_o      head exception
//   commit_ack_i            pop the head (ignored while commit_valid_o is low)
//   wb_error_o              sticky writeback protocol violation

package wb_result_buffer_pkg;
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;
endpackage

module wb_result_buffer
  import wb_result_buffer_pkg::*;
#(
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                alloc_valid_i,
  output logic                                alloc_ready_o,
  output logic [TRANS_ID_BITS-1:0]            alloc_trans_id_o,
  input  logic [3:0]                          wb_valid_i,
  input  logic [3:0][TRANS_ID_BITS-1:0]       wb_trans_id_i,
  input  logic [3:0][63:0]                    wb_result_i,
  input  exception_t [3:0]                    wb_exception_i,
  output logic                                commit_valid_o,
  output logic [TRANS_ID_BITS-1:0]            commit_trans_id_o,
  output logic [63:0]                         commit_result_o,
  output exception_t                          commit_exception_o,
  input  logic                                commit_ack_i,
  output logic                                wb_error_o
);

  localparam int unsigned NR_ENTRIES = 2 ** TRANS_ID_BITS;
  localparam int unsigned NR_PORTS   = 4;
  localparam logic [TRANS_ID_BITS:0] FULL_COUNT = (TRANS_ID_BITS + 1)'(NR_ENTRIES);

  logic [NR_ENTRIES-1:0]    alloc;
  logic [NR_ENTRIES-1:0]    done;
  logic [NR_ENTRIES-1:0]    alloc_next;
  logic [NR_ENTRIES-1:0]    done_next;
  logic [63:0]              result    [NR_ENTRIES];
  exception_t               exception [NR_ENTRIES];

  logic [TRANS_ID_BITS-1:0] head;
  logic [TRANS_ID_BITS-1:0] tail;
  logic [TRANS_ID_BITS:0]   count;
  logic [TRANS_ID_BITS-1:0] head_next;
  logic [TRANS_ID_BITS-1:0] tail_next;
  logic [TRANS_ID_BITS:0]   count_next;
  logic                     wb_error;

  logic                     alloc_fire;
  logic                     commit_fire;
  logic [NR_PORTS-1:0]      wb_win;
  logic [NR_PORTS-1:0]      wb_legal;
  logic                     wb_bad;

  // Ready depends only on the registered count, so a commit in the same
  // cycle cannot free a slot for that cycle's allocation.
  assign alloc_ready_o    = (count != FULL_COUNT);
  assign alloc_trans_id_o = tail;
  assign alloc_fire       = alloc_valid_i & alloc_ready_o;

  // Commit outputs are read straight from entry registers: no wb bypass.
  assign commit_valid_o     = alloc[head] & done[head];
  assign commit_trans_id_o  = head;
  assign commit_result_o    = result[head];
  assign commit_exception_o = exception[head];
  assign commit_fire        = commit_ack_i & commit_valid_o;

  assign wb_error_o = wb_error;

  // A port wins its ID unless a lower-indexed port targets the same ID in
  // this cycle. A winner is only captured if the entry was already
  // allocated (before this edge) and not yet written, so a write to an
  // entry being allocated in this same cycle is rejected too.
  always_comb begin
    wb_win   = '0;
    wb_legal = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      wb_win[p] = wb_valid_i[p];
      for (int q = 0; q < p; q++) begin
        if (wb_valid_i[q] && (wb_trans_id_i[q] == wb_trans_id_i[p])) begin
          wb_win[p] = 1'b0;
        end
      end
      wb_legal[p] = wb_win[p] & alloc[wb_trans_id_i[p]] & ~done[wb_trans_id_i[p]];
    end
  end

  assign wb_bad = |(wb_valid_i & ~wb_legal);

  // Bookkeeping next state. Writebacks never hit the head being committed
  // (it is already done) nor the tail being allocated (it is not yet
  // allocated), so the update order below has no real conflicts.
  always_comb begin
    alloc_next = alloc;
    done_next  = done;
    head_next  = head;
    tail_next  = tail;
    count_next = count;

    for (int p = 0; p < NR_PORTS; p++) begin
      if (wb_legal[p]) begin
        done_next[wb_trans_id_i[p]] = 1'b1;
      end
    end

    if (commit_fire) begin
      alloc_next[head] = 1'b0;
      done_next[head]  = 1'b0;
      head_next        = head + TRANS_ID_BITS'(1);
    end

    if (alloc_fire) begin
      alloc_next[tail] = 1'b1;
      done_next[tail]  = 1'b0;
      tail_next        = tail + TRANS_ID_BITS'(1);
    end

    case ({alloc_fire, commit_fire})
      2'b10:   count_next = count + (TRANS_ID_BITS + 1)'(1);
      2'b01:   count_next = count - (TRANS_ID_BITS + 1)'(1);
      default: count_next = count;
    endcase

    if (flush_i) begin
      alloc_next = '0;
      done_next  = '0;
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alloc    <= '0;
      done     <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wb_error <= 1'b0;
    end else begin
      alloc <= alloc_next;
      done  <= done_next;
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
      // Sticky: only reset clears it, flush leaves it alone.
      if (wb_bad) begin
        wb_error <= 1'b1;
      end
    end
  end

  // Entry payload. Winners carry distinct IDs, so at most one port matches
  // each entry per cycle. The exception is stored even when not valid.
  for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        result[gi]    <= '0;
        exception[gi] <= '0;
      end else if (!flush_i) begin
        for (int p = 0; p < NR_PORTS; p++) begin
          if (wb_legal[p] && (wb_trans_id_i[p] == TRANS_ID_BITS'(gi))) begin
            result[gi]    <= wb_result_i[p];
            exception[gi] <= wb_exception_i[p];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_result_buffer.sv
module tb_wb_result_buffer;
  import wb_result_buffer_pkg::*;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [2:0]       alloc_trans_id;
  logic [3:0]       wb_valid;
  logic [3:0][2:0]  wb_trans_id;
  logic [3:0][63:0] wb_result;
  exception_t [3:0] wb_exception;
  logic             commit_valid;
  logic [2:0]       commit_trans_id;
  logic [63:0]      commit_result;
  exception_t       commit_exception;
  logic             commit_ack;
  logic             wb_error;

  int errors = 0;
  int checks = 0;

  wb_result_buffer #(.TRANS_ID_BITS(3)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .alloc_valid_i      (alloc_valid),
    .alloc_ready_o      (alloc_ready),
    .alloc_trans_id_o   (alloc_trans_id),
    .wb_valid_i         (wb_valid),
    .wb_trans_id_i      (wb_trans_id),
    .wb_result_i        (wb_result),
    .wb_exception_i     (wb_exception),
    .commit_valid_o     (commit_valid),
    .commit_trans_id_o  (commit_trans_id),
    .commit_result_o    (commit_result),
    .commit_exception_o (commit_exception),
    .commit_ack_i       (commit_ack),
    .wb_error_o         (wb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked
  // in the same window, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid     = '0;
    wb_trans_id  = '0;
    wb_result    = '0;
    wb_exception = '0;
  endtask

  task automatic alloc_n(input int n, input int first_id);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      check("alloc_ready", 64'(alloc_ready), 64'd1);
      check("alloc_id", 64'(alloc_trans_id), 64'((first_id + i) % 8));
      $display("alloc id=%0d", alloc_trans_id);
      step();
    end
    alloc_valid = 1'b0;
  endtask

  task automatic set_wb(input int p, input int id, input logic [63:0] res);
    wb_valid[p]     = 1'b1;
    wb_trans_id[p]  = 3'(id);
    wb_result[p]    = res;
    wb_exception[p] = '0;
  endtask

  task automatic wb_one(input int p, input int id, input logic [63:0] res);
    set_wb(p, id, res);
    $display("writeback port=%0d id=%0d result=0x%0h", p, id, res);
    step();
    clear_wb();
  endtask

  task automatic pop(input string tag, input int id, input logic [63:0] res);
    check({tag, "_valid"}, 64'(commit_valid), 64'd1);
    check({tag, "_id"}, 64'(commit_trans_id), 64'(id));
    check({tag, "_result"}, commit_result, res);
    $display("commit id=%0d result=0x%0h", commit_trans_id, commit_result);
    commit_ack = 1'b1;
    step();
    commit_ack = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alloc_ready"}, 64'(alloc_ready), 64'd1);
    check({tag, "_alloc_id"}, 64'(alloc_trans_id), 64'd0);
    check({tag, "_commit_valid"}, 64'(commit_valid), 64'd0);
    check({tag, "_commit_id"}, 64'(commit_trans_id), 64'd0);
    check({tag, "_commit_result"}, commit_result, 64'd0);
    check({tag, "_exc_cause"}, commit_exception.cause, 64'd0);
    check({tag, "_exc_tval"}, commit_exception.tval, 64'd0);
    check({tag, "_exc_valid"}, 64'(commit_exception.valid), 64'd0);
    check({tag, "_wb_error"}, 64'(wb_error), 64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    alloc_valid = 1'b0;
    commit_ack  = 1'b0;
    clear_wb();
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // ---- Fill and wrap ----
    alloc_n(8, 0);
    check("full_ready", 64'(alloc_ready), 64'd0);
    wb_one(0, 0, 64'h100);
    // Commit and allocate in the same cycle while full: no slot yet.
    check("wrap_head_valid", 64'(commit_valid), 64'd1);
    check("wrap_head_result", commit_result, 64'h100);
    alloc_valid = 1'b1;
    commit_ack  = 1'b1;
    check("full_during_commit", 64'(alloc_ready), 64'd0);
    step();
    commit_ack  = 1'b0;
    alloc_valid = 1'b0;
    alloc_n(1, 0);
    check("refull_ready", 64'(alloc_ready), 64'd0);
    for (int p = 0; p < 4; p++) set_wb(p, p + 1, 64'h100 + 64'(p + 1));
    step();
    clear_wb();
    for (int p = 0; p < 4; p++) begin
      int id;
      id = (p + 5) % 8;
      set_wb(p, id, (id == 0) ? 64'h200 : 64'h100 + 64'(id));
    end
    step();
    clear_wb();
    for (int k = 1; k < 8; k++) pop("wrap", k, 64'h100 + 64'(k));
    pop("wrap0", 0, 64'h200);
    check("wrap_empty_valid", 64'(commit_valid), 64'd0);
    check("wrap_empty_ready", 64'(alloc_ready), 64'd1);
    check("wrap_wb_error", 64'(wb_error), 64'd0);
    flush_pulse();

    // ---- Out-of-order completion ----
    alloc_n(3, 0);
    wb_one(1, 2, 64'hAAAA);
    check("ooo_id2_only", 64'(commit_valid), 64'd0);
    wb_one(0, 0, 64'h1111);
    pop("ooo0", 0, 64'h1111);
    check("ooo_blocked", 64'(commit_valid), 64'd0);
    check("ooo_blocked_id", 64'(commit_trans_id), 64'd1);
    wb_one(2, 1, 64'h2222);
    pop("ooo1", 1, 64'h2222);
    pop("ooo2", 2, 64'hAAAA);
    check("ooo_empty", 64'(commit_valid), 64'd0);
    flush_pulse();

    // ---- Parallel writeback ----
    alloc_n(4, 0);
    for (int p = 0; p < 4; p++) set_wb(p, p, 64'hC000 + 64'(p));
    step();
    clear_wb();
    for (int k = 0; k < 4; k++) pop("par", k, 64'hC000 + 64'(k));
    check("par_wb_error", 64'(wb_error), 64'd0);
    flush_pulse();

    // ---- Exception passthrough ----
    alloc_n(1, 0);
    set_wb(2, 0, 64'h55);
    wb_exception[2].valid = 1'b1;
    wb_exception[2].cause = 64'd7;
    wb_exception[2].tval  = 64'h8000_0000;
    step();
    clear_wb();
    check("exc_valid", 64'(commit_exception.valid), 64'd1);
    check("exc_cause", commit_exception.cause, 64'd7);
    check("exc_tval", commit_exception.tval, 64'h8000_0000);
    pop("exc", 0, 64'h55);
    flush_pulse();

    // ---- Collision and illegal writeback ----
    alloc_n(2, 0);
    set_wb(0, 1, 64'hF1);
    set_wb(3, 1, 64'hF4);
    check("coll_pre_error", 64'(wb_error), 64'd0);
    step();
    clear_wb();
    check("coll_error", 64'(wb_error), 64'd1);
    wb_one(1, 0, 64'h10);
    pop("coll0", 0, 64'h10);
    pop("coll1", 1, 64'hF1);
    wb_one(2, 5, 64'h5555);
    alloc_n(4, 2);
    for (int p = 0; p < 3; p++) set_wb(p, p + 2, 64'h22 * 64'(p + 1) + 64'h0);
    step();
    clear_wb();
    pop("ill2", 2, 64'h22);
    pop("ill3", 3, 64'h44);
    pop("ill4", 4, 64'h66);
    check("ill5_dropped", 64'(commit_valid), 64'd0);
    check("ill5_head", 64'(commit_trans_id), 64'd5);
    wb_one(3, 5, 64'h5A5A);
    pop("ill5", 5, 64'h5A5A);
    // Writeback to the entry being allocated this same cycle is dropped.
    alloc_valid = 1'b1;
    set_wb(0, 6, 64'h66);
    step();
    alloc_valid = 1'b0;
    clear_wb();
    check("same_cycle_dropped", 64'(commit_valid), 64'd0);
    wb_one(0, 6, 64'h67);
    pop("same_cycle", 6, 64'h67);

    // ---- Flush overrides everything ----
    flush_pulse();
    alloc_n(5, 0);
    wb_one(0, 0, 64'hAB);
    check("pre_flush_valid", 64'(commit_valid), 64'd1);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    commit_ack  = 1'b1;
    set_wb(1, 1, 64'hCD);
    step();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    commit_ack  = 1'b0;
    clear_wb();
    check("flush_valid", 64'(commit_valid), 64'd0);
    check("flush_ready", 64'(alloc_ready), 64'd1);
    check("flush_alloc_id", 64'(alloc_trans_id), 64'd0);
    check("flush_head", 64'(commit_trans_id), 64'd0);
    check("flush_sticky_error", 64'(wb_error), 64'd1);
    alloc_n(1, 0);
    check("flush_done_cleared", 64'(commit_valid), 64'd0);
    wb_one(0, 0, 64'hEE);
    pop("post_flush", 0, 64'hEE);
    check("post_flush_tail", 64'(alloc_trans_id), 64'd1);

    // ---- Asynchronous reset mid-stream ----
    alloc_n(1, 1);
    wb_one(0, 1, 64'h77);
    check("pre_rst_valid", 64'(commit_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #1;
    rst = 1'b0;
    step();
    check("post_rst_ready", 64'(alloc_ready), 64'd1);
    check("post_rst_alloc_id", 64'(alloc_trans_id), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_result_buffer.md
# wb_result_buffer

In-order writeback collector on the far side of the execute stage's result ports. It takes the four writeback ports (fixed-latency unit, load, store, FPU), each tagged with a scoreboard transaction ID, and parks each result, with its exception, in a per-ID entry. It hands out IDs at issue time and presents entries to commit strictly in allocation order. It is the writeback/commit half of the scoreboard and tolerates out-of-order completion.

## Interface
Parameters:
- TRANS_ID_BITS, default 3: transaction ID width. Buffer depth is NR_ENTRIES = 2**TRANS_ID_BITS.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- flush_i  in  1  discard all entries.
- alloc_valid_i  in  1  issue requests an ID.
- alloc_ready_o  out  1  buffer not full.
- alloc_trans_id_o  out  TRANS_ID_BITS  ID granted on alloc_valid_i & alloc_ready_o (current tail).
- wb_valid_i[p]  in  4x1  writeback strobe. Port order is p=0 flu, 1 load, 2 store, 3 fpu.
- wb_trans_id_i[p]  in  4xTRANS_ID_BITS  target entry.
- wb_result_i[p]  in  4x64  result data.
- wb_exception_i[p]  in  4x exception_t  exception (cause, tval, valid).
- commit_valid_o  out  1  head entry allocated and written back.
- commit_trans_id_o  out  TRANS_ID_BITS  head pointer.
- commit_result_o  out  64  head result.
- commit_exception_o  out  exception_t  head exception.
- commit_ack_i  in  1  pop the head; honoured only while commit_valid_o is high.
- wb_error_o  out  1  sticky protocol-violation flag; cleared only by reset.

## Operation
- State per entry: alloc bit, done bit, result[63:0], exception_t. Pointers: head and tail, each TRANS_ID_BITS wide, wrapping modulo NR_ENTRIES. Occupancy count is TRANS_ID_BITS+1 bits wide.
- Allocate: on alloc_valid_i & alloc_ready_o, set alloc[tail], clear done[tail], then tail++.
- Writeback: on wb_valid_i[p] with alloc[id] & !done[id], capture result and exception and set done[id]. The exception is stored even when its valid bit is 0.
- Invalid writeback: a writeback to an entry that is unallocated, already done, or allocated in this same cycle is dropped and sets wb_error_o.
- Same-ID collision: two ports writing the same ID in one cycle. Lowest port index wins (flu > load > store > fpu). The losing ports are dropped and set wb_error_o.
- Distinct-ID writebacks: all four ports may write distinct IDs in the same cycle, and all are captured.
- Commit: commit_valid_o = alloc[head] & done[head]. Its outputs come from registered entry state (no writeback bypass). On commit_ack_i & commit_valid_o, clear alloc[head] and done[head], then head++. commit_ack_i while commit_valid_o is low is ignored.
- Full/empty: alloc_ready_o = (count != NR_ENTRIES), computed from the current count. A same-cycle commit does not free a slot for that cycle's allocation. Allocation and commit in the same cycle leave count unchanged.
- Flush: flush_i clears every alloc and done bit, head, tail and count. It overrides allocation, writeback and commit in the same cycle. wb_error_o is not affected.
- Reset (any time, including mid-operation): all entries cleared, head = tail = count = 0.
  - alloc_ready_o=1, alloc_trans_id_o=0.
  - commit_valid_o=0, commit_trans_id_o=0, commit_result_o=0, commit_exception_o='0.
  - wb_error_o=0.

## Timing
- Allocation is granted combinationally in cycle N. The ID is writable from cycle N+1.
- A writeback captured at edge N makes commit_valid_o high in cycle N+1, provided that entry is the head.
- Minimum allocate-to-commit: allocate in N, writeback in N+1, commit_valid_o in N+2.
- Commit throughput: one entry per cycle. After an ack at edge N, the next head is visible in N+1.
- flush_i asserted in cycle N: from N+1, commit_valid_o=0, alloc_ready_o=1 and alloc_trans_id_o=0.
- No combinational path from any wb_* input to commit_* outputs or alloc_ready_o.

## Test plan
- Fill and wrap:
  - Allocate 8 IDs (0..7) back-to-back, then alloc_ready_o=0.
  - Write back and commit ID 0, then allocate again: granted ID 0.
  - Commit order must be 0..7, then 0.
- Out-of-order completion:
  - Allocate 0,1,2. Write back ID 2 via the load port with 0xAAAA, then ID 0 via the flu port with 0x1111.
  - commit_valid_o rises only for ID 0, with result 0x1111.
  - ID 1 blocks ID 2 until ID 1 is written.
- Parallel writeback:
  - All four ports write IDs 0..3 in the same cycle.
  - Four consecutive commits return all four results, with wb_error_o=0.
- Collision and illegal writeback:
  - flu and fpu both write ID 1 in one cycle: the flu data is committed and wb_error_o=1.
  - A write to an unallocated ID 5 is dropped.
- Exception passthrough:
  - The store port writes ID 0 with exception valid=1, cause=7, tval=0x8000_0000.
  - commit_exception_o carries exactly those values.
- Flush and reset:
  - With 5 entries live, pulse flush_i together with an alloc, a writeback and an ack: the next cycle shows an empty buffer with alloc_trans_id_o=0.
  - Assert rst_i mid-stream: all outputs return to their reset values asynchronously.
